// File: rtl/polyphase_capture_ctrl.sv
// -----------------------------------------------------------------------------
// polyphase_capture_ctrl
//
// Sequences a two-path polyphase ADC test capture. After START is accepted,
// the block waits a programmable settle time. It then splits the incoming
// sample stream into even/odd pairs, NPAIR times, and presents each pair to
// the readout through a valid/ready handshake. An internal phase bit stands
// in for a half-rate clock, so everything runs in the single clk domain.
//
// Parameters
//   BW : sample width (signed two's complement)
//   CW : width of the settle and pair counters
//
// Ports
//   clk    : system clock, rising edge
//   res    : asynchronous active-low reset
//   start  : begin capture (only looked at in IDLE)
//   abort  : synchronous return to IDLE from any busy state
//   settle : settle length, captured when START is accepted
//   npair  : number of pairs to capture, captured when START is accepted
//   in     : ADC sample, one per clk
//   rdy    : readout takes the pair on a cycle with vld & rdy
//   out1   : later (odd-phase) sample of the pair
//   out2   : earlier (even-phase) sample of the pair
//   vld    : out1/out2 hold a pair that has not been consumed
//   busy   : high in SETTLE, CAPTURE and DRAIN
//   done   : one-cycle pulse on normal completion
//   ovf    : sticky, set when a pair is overwritten before being consumed
//   pcnt   : pairs captured in the current or last run
// -----------------------------------------------------------------------------
module polyphase_capture_ctrl #(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CW-1:0]        settle,
    input  logic [CW-1:0]        npair,
    input  logic signed [BW-1:0] in,
    input  logic                 rdy,
    output logic signed [BW-1:0] out1,
    output logic signed [BW-1:0] out2,
    output logic                 vld,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [CW-1:0]        pcnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t                state_reg;
    logic [CW-1:0]         scnt_reg;
    logic [CW-1:0]         npair_reg;
    logic [CW-1:0]         pcnt_reg;
    logic                  ph_reg;
    logic signed [BW-1:0]  z1_reg;
    logic signed [BW-1:0]  out1_reg;
    logic signed [BW-1:0]  out2_reg;
    logic                  vld_reg;
    logic                  done_reg;
    logic                  ovf_reg;

    // Count after the pair landing this cycle; used both as the new pcnt
    // and for the end-of-run test, so DRAIN is entered on the same edge.
    logic [CW-1:0]         pcnt_inc;

    assign pcnt_inc = pcnt_reg + CW'(1);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= ST_IDLE;
            scnt_reg  <= '0;
            npair_reg <= '0;
            pcnt_reg  <= '0;
            ph_reg    <= 1'b0;
            z1_reg    <= '0;
            out1_reg  <= '0;
            out2_reg  <= '0;
            vld_reg   <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A zero-length request is ignored outright.
                    if (start && (npair != '0)) begin
                        scnt_reg  <= settle;
                        npair_reg <= npair;
                        pcnt_reg  <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        vld_reg   <= 1'b0;
                        ph_reg    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (scnt_reg == '0) begin
                        ph_reg    <= 1'b0;
                        state_reg <= ST_CAPTURE;
                    end else begin
                        scnt_reg <= scnt_reg - CW'(1);
                    end
                end

                ST_CAPTURE: begin
                    if (abort) begin
                        // The half-captured even sample in z1 is simply dropped.
                        vld_reg   <= 1'b0;
                        ph_reg    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        ph_reg <= ~ph_reg;
                        if (!ph_reg) begin
                            // Even phase: hold the sample until its partner arrives.
                            z1_reg <= in;
                            if (vld_reg && rdy) begin
                                vld_reg <= 1'b0;
                            end
                        end else begin
                            // Odd phase: a new pair lands. If the previous pair is
                            // still pending and not taken this cycle, it is lost.
                            out1_reg <= in;
                            out2_reg <= z1_reg;
                            vld_reg  <= 1'b1;
                            pcnt_reg <= pcnt_inc;
                            if (vld_reg && !rdy) begin
                                ovf_reg <= 1'b1;
                            end
                            if (pcnt_inc == npair_reg) begin
                                state_reg <= ST_DRAIN;
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    if (abort) begin
                        vld_reg   <= 1'b0;
                        ph_reg    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (!vld_reg || rdy) begin
                        // Last pair consumed on this edge: finish the run.
                        vld_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out1 = out1_reg;
    assign out2 = out2_reg;
    assign vld  = vld_reg;
    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign ovf  = ovf_reg;
    assign pcnt = pcnt_reg;

endmodule

// File: tb/tb_polyphase_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_polyphase_capture_ctrl
//
// Scoreboard bench. The stimulus process drives inputs once per cycle and
// feeds a schedule-based reference model. The model knows the edge on which
// START was accepted. From that it works out, with plain arithmetic, the edges
// on which pairs land and when the run can finish. It pushes each pair the
// readout should take, and each expected DONE, into queues. A separate monitor
// pops those queues whenever the DUT shows vld&rdy or done. It also checks
// busy/vld/pcnt/ovf every cycle.
// -----------------------------------------------------------------------------
module tb_polyphase_capture_ctrl;

    localparam int BW = 6;
    localparam int CW = 8;

    logic                 clk     = 1'b0;
    logic                 res     = 1'b1;
    logic                 start   = 1'b0;
    logic                 abort   = 1'b0;
    logic                 rdy     = 1'b0;
    logic [CW-1:0]        settle  = '0;
    logic [CW-1:0]        npair_i = '0;
    logic signed [BW-1:0] din     = '0;

    logic signed [BW-1:0] out1;
    logic signed [BW-1:0] out2;
    logic                 vld;
    logic                 busy;
    logic                 done;
    logic                 ovf;
    logic [CW-1:0]        pcnt;

    always #5 clk = ~clk;

    polyphase_capture_ctrl #(.BW(BW), .CW(CW)) dut (
        .clk    (clk),
        .res    (res),
        .start  (start),
        .abort  (abort),
        .settle (settle),
        .npair  (npair_i),
        .in     (din),
        .rdy    (rdy),
        .out1   (out1),
        .out2   (out2),
        .vld    (vld),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .pcnt   (pcnt)
    );

    typedef struct {
        logic signed [BW-1:0] o1;
        logic signed [BW-1:0] o2;
    } pair_t;

    typedef struct {
        logic [CW-1:0] pc;
        logic          ov;
    } done_t;

    pair_t pair_q[$];
    done_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle expectations, valid for the cycle currently being driven.
    bit            chk_en   = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_vld  = 1'b0;
    logic [CW-1:0] exp_pcnt = '0;
    logic          exp_ovf  = 1'b0;

    // Reference model state.
    bit                   m_active = 1'b0;
    bit                   m_pend   = 1'b0;
    bit                   m_ovf    = 1'b0;
    logic [CW-1:0]        m_pcnt   = '0;
    logic signed [BW-1:0] m_o1     = '0;
    logic signed [BW-1:0] m_o2     = '0;
    logic signed [BW-1:0] m_prev   = '0;
    int                   m_edge   = 0;
    int                   m_t0     = 0;
    int                   m_s      = 0;
    int                   m_n      = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Does a pair land on the upcoming edge? Edge 0 of a run is the START
    // accept. Settle occupies edges 1..S+1. Pair k is then formed by the
    // samples taken on edges S+2+2k and S+3+2k.
    function automatic bit lands_next();
        int rel;
        if (!m_active) return 1'b0;
        rel = m_edge - m_t0;
        return (rel >= m_s + 2) && (rel <= m_s + 2 * m_n + 1) && (((rel - m_s - 2) % 2) == 1);
    endfunction

    // Advance the model over the upcoming edge, using the inputs now driven.
    task automatic model_edge();
        bit    consumed;
        int    rel;
        pair_t p;
        done_t d;
        consumed = m_pend && rdy;
        if (consumed) begin
            p.o1 = m_o1;
            p.o2 = m_o2;
            pair_q.push_back(p);
        end
        if (!m_active) begin
            if (start && (npair_i != 0)) begin
                m_active = 1'b1;
                m_t0     = m_edge;
                m_s      = int'(settle);
                m_n      = int'(npair_i);
                m_pcnt   = '0;
                m_ovf    = 1'b0;
            end
        end else if (abort) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
        end else begin
            rel = m_edge - m_t0;
            if (lands_next()) begin
                if (m_pend && !rdy) m_ovf = 1'b1;
                m_pend = 1'b1;
                m_o1   = din;
                m_o2   = m_prev;
                m_pcnt = m_pcnt + 1'b1;
            end else if (rel > m_s + 2 * m_n + 1) begin
                if (!m_pend || rdy) begin
                    m_pend   = 1'b0;
                    m_active = 1'b0;
                    d.pc     = m_pcnt;
                    d.ov     = m_ovf;
                    done_q.push_back(d);
                end
            end else if (consumed) begin
                m_pend = 1'b0;
            end
        end
        m_prev = din;
        m_edge++;
    endtask

    // Drive one cycle. Called just after a rising edge; returns just after the next.
    task automatic cyc(input logic st, input logic ab, input logic [CW-1:0] s,
                       input logic [CW-1:0] n, input logic signed [BW-1:0] d, input logic r);
        start   = st;
        abort   = ab;
        settle  = s;
        npair_i = n;
        din     = d;
        rdy     = r;
        exp_busy = m_active;
        exp_vld  = m_pend;
        exp_pcnt = m_pcnt;
        exp_ovf  = m_ovf;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, r);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out1"}, out1, 0);
        chk({tag, "_out2"}, out2, 0);
        chk({tag, "_vld"},  vld,  0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"},  ovf,  0);
        chk({tag, "_pcnt"}, pcnt, 0);
    endtask

    // Monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (res && chk_en) begin
            chk("busy", busy, exp_busy);
            chk("vld",  vld,  exp_vld);
            chk("pcnt", pcnt, exp_pcnt);
            chk("ovf",  ovf,  exp_ovf);
            if (vld && rdy) begin
                if (pair_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pair_unexpected: got out1=%0d out2=%0d, expected no pair", out1, out2);
                end else begin
                    pair_t p;
                    p = pair_q.pop_front();
                    $display("pair taken: out1=%0d out2=%0d pcnt=%0d", out1, out2, pcnt);
                    chk("out1", out1, p.o1);
                    chk("out2", out2, p.o2);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: got done=1, expected done=0");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    $display("run done: pcnt=%0d ovf=%0d", pcnt, ovf);
                    chk("done_pcnt", pcnt, d.pc);
                    chk("done_ovf",  ovf,  d.ov);
                end
            end
        end
    end

    initial begin
        logic signed [BW-1:0] sv;
        int                   rdy_bias;

        // Power-on reset.
        #1 res = 1'b0;
        #2 check_all_zero("reset");
        #18 res = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Basic run: SETTLE=2, NPAIR=3, ready always high, counting samples.
        cyc(1'b1, 1'b0, 8'd2, 8'd3, 6'sd0, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, '0, '0, BW'(i - 2), 1'b1);
        idle(2, 1'b1);

        // Backpressure: no ready through capture, so the first pair is overwritten.
        cyc(1'b1, 1'b0, 8'd1, 8'd2, 6'sd0, 1'b0);
        for (int i = 1; i < 10; i++) cyc(1'b0, 1'b0, '0, '0, BW'(i + 7), 1'b0);
        idle(2, 1'b1);
        idle(2, 1'b0);

        // Abort during settle; START also clears the sticky overflow.
        cyc(1'b1, 1'b0, 8'd5, 8'd2, 6'sd0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 6'sd0, 1'b1);
        cyc(1'b0, 1'b1, '0, '0, 6'sd0, 1'b1);
        idle(3, 1'b1);

        // Abort mid-capture after one pair has landed.
        cyc(1'b1, 1'b0, 8'd0, 8'd3, 6'sd0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 6'sd5, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 6'sd6, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 6'sd7, 1'b1);
        cyc(1'b0, 1'b1, '0, '0, 6'sd8, 1'b1);
        idle(3, 1'b1);

        // Signed extremes pass through bit-exact.
        cyc(1'b1, 1'b0, 8'd0, 8'd1, 6'sd0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 6'sd0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, -6'sd32, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 6'sd31, 1'b1);
        idle(3, 1'b1);

        // NPAIR=0 start must be ignored; ABORT+START in IDLE: START wins.
        cyc(1'b1, 1'b0, 8'd3, 8'd0, 6'sd0, 1'b1);
        idle(2, 1'b1);
        cyc(1'b1, 1'b1, 8'd0, 8'd1, 6'sd0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0, '0, BW'(i * 9), 1'b1);

        // Asynchronous reset mid-capture, asserted between clock edges.
        cyc(1'b1, 1'b0, 8'd0, 8'd4, 6'sd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, '0, BW'(i + 20), 1'b0);
        #2 res = 1'b0;
        #1 check_all_zero("async");
        start = 1'b0; abort = 1'b0; rdy = 1'b0;
        m_active = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_pcnt = '0;
        exp_busy = 1'b0; exp_vld = 1'b0; exp_pcnt = '0; exp_ovf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 res = 1'b1;
        m_edge++;
        m_edge++;
        cyc(1'b1, 1'b0, 8'd0, 8'd1, 6'sd0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, '0, BW'(-i - 3), 1'b1);

        // Ready high exactly on each landing cycle: vld must never drop between pairs.
        cyc(1'b1, 1'b0, 8'd0, 8'd4, 6'sd0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, '0, '0, BW'(i * 5 + 1), lands_next());
        idle(3, 1'b1);

        // Randomised traffic.
        rdy_bias = 2;
        for (int i = 0; i < 2500; i++) begin
            if ((i % 200) == 0) rdy_bias = $urandom_range(0, 3);
            sv = BW'($urandom);
            cyc(($urandom_range(0, 5) == 0),
                ($urandom_range(0, 59) == 0),
                CW'($urandom_range(0, 5)),
                CW'($urandom_range(0, 6)),
                sv,
                ($urandom_range(0, 3) <= rdy_bias));
        end
        idle(40, 1'b1);

        chk("pair_q_left", pair_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
